// File: rtl/seg7_scan_mux_pkg.sv
// rtl/seg7_scan_mux_pkg.sv - shared glyph table and segment index map for the scan mux
package seg7_scan_mux_pkg;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_idx_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a}; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_mux_if.sv
// rtl/seg7_scan_mux_if.sv - value/control inputs and display pin outputs of the scan mux
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    hex_mode;
    logic                    lzs;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, dp_in, load, hex_mode, lzs,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, load, hex_mode, lzs,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_mux_hex7_decode.sv
// rtl/seg7_scan_mux_hex7_decode.sv - nibble to active-high 7-segment glyph, hex or BCD
module hex7_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       hex_mode_i,
    output logic [6:0] glyph_o
);
    // BCD mode shows nothing for codes above 9.
    assign glyph_o = (!hex_mode_i && nib_i > 4'd9) ? SEG_BLANK : GLYPHS[nib_i];
endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed multi-digit 7-segment driver with double-buffered values
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_mux_if.slave   bus
);
    localparam int   PW   = $clog2(REFRESH_DIV);
    localparam int   IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL  = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] stage_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0]   stage_dp_q, disp_dp_q;
    logic                    pending_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q;

    logic                    tick, last_digit, frame_cond, blank, suppress;
    logic [3:0]              cur_nib;
    logic [6:0]              glyph, seg_hi;
    logic                    dp_hi;
    logic [NUM_DIGITS:0]     zero_from;

    assign tick       = (pcnt_q == PW'(REFRESH_DIV - 1));
    assign last_digit = (idx_q == IDXW'(NUM_DIGITS - 1));
    assign frame_cond = tick && last_digit;
    assign pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
    assign idx_d      = !tick ? idx_q : (last_digit ? '0 : idx_q + 1'b1);
    assign blank      = (pcnt_q < PW'(BLANK_CYCLES));

    // zero_from[i]: display nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp_val_q[4*i +: 4] == 4'd0);
        end
    end

    assign cur_nib  = disp_val_q[{idx_q, 2'b00} +: 4];
    assign suppress = bus.lzs && (idx_q != '0) && zero_from[idx_q];

    hex7_decode u_decode (
        .nib_i      (cur_nib),
        .hex_mode_i (bus.hex_mode),
        .glyph_o    (glyph)
    );

    always_comb begin
        an_d   = '1;
        seg_hi = SEG_BLANK;
        dp_hi  = 1'b0;
        if (!blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (IDXW'(i) != idx_q);
            end
            seg_hi = suppress ? SEG_BLANK : glyph;
            dp_hi  = disp_dp_q[idx_q];
        end
        seg_d = seg_hi ^ {7{POL}};
        dp_d  = dp_hi ^ POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= {7{POL}};
            dp_q         <= POL;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_cond;
            if (frame_cond && pending_q) begin
                disp_val_q <= stage_val_q;
                disp_dp_q  <= stage_dp_q;
            end
            // A load on the commit cycle must survive to the next frame, so it wins over the clear.
            if (bus.load) begin
                stage_val_q <= bus.value;
                stage_dp_q  <= bus.dp_in;
                pending_q   <= 1'b1;
            end else if (frame_cond) begin
                pending_q   <= 1'b0;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - directed self-checking bench for seg7_scan_mux
module tb_seg7_scan_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    seg7_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_mux #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp_in = d;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    // Go to the middle of digit d's lit window in the frame starting at base and check the pins.
    task automatic chk_digit(input string tag, input int base, input int d,
                             input logic [6:0] exp_seg, input logic exp_dp);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << d);
        goto(base + 8*d + 4);
        check({tag, "_an"}, bus.an, exp_an);
        check({tag, "_seg"}, bus.seg, exp_seg);
        check({tag, "_dp"}, bus.dp, exp_dp);
    endtask

    initial begin
        logic [3:0] an_exp;
        bus.value = '0; bus.dp_in = '0; bus.load = 1'b0; bus.hex_mode = 1'b1; bus.lzs = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_an", bus.an, 4'hF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp", bus.dp, 1'b1);
        check("rst_fd", bus.frame_done, 1'b0);
        rst_n = 1'b1;
        cyc = 0;

        for (int k = 1; k <= 12; k++) begin
            step();
            an_exp = (k <= 2) ? 4'hF : (k <= 8) ? 4'hE : (k <= 10) ? 4'hF : 4'hD;
            check($sformatf("scan_an_c%0d", k), bus.an, an_exp);
        end

        goto(31); check("fd_31", bus.frame_done, 1'b0);
        goto(32); check("fd_32", bus.frame_done, 1'b1);
        goto(33); check("fd_33", bus.frame_done, 1'b0);

        goto(40); load_val(16'h1234, 4'h0);
        chk_digit("old_d3", 32, 3, 7'h40, 1'b1);
        goto(64); check("fd_64", bus.frame_done, 1'b1);
        chk_digit("new_d0", 64, 0, 7'h19, 1'b1);
        chk_digit("new_d3", 64, 3, 7'h79, 1'b1);

        goto(100); load_val(16'hABCF, 4'b0010);
        chk_digit("hex_d0", 128, 0, 7'h0E, 1'b1);
        chk_digit("hex_d1", 128, 1, 7'h46, 1'b0);
        chk_digit("hex_d2", 128, 2, 7'h03, 1'b1);
        chk_digit("hex_d3", 128, 3, 7'h08, 1'b1);
        goto(159); bus.hex_mode = 1'b0;
        for (int d = 0; d < 4; d++)
            chk_digit($sformatf("bcd_d%0d", d), 160, d, 7'h7F, (d == 1) ? 1'b0 : 1'b1);
        bus.hex_mode = 1'b1;

        bus.lzs = 1'b1;
        goto(196); load_val(16'h0050, 4'b1000);
        chk_digit("lzs_d0", 224, 0, 7'h40, 1'b1);
        chk_digit("lzs_d1", 224, 1, 7'h12, 1'b1);
        chk_digit("lzs_d2", 224, 2, 7'h7F, 1'b1);
        chk_digit("lzs_d3", 224, 3, 7'h7F, 1'b0);
        goto(228); load_val(16'h0000, 4'h0);
        chk_digit("lz0_d0", 256, 0, 7'h40, 1'b1);
        chk_digit("lz0_d1", 256, 1, 7'h7F, 1'b1);
        chk_digit("lz0_d3", 256, 3, 7'h7F, 1'b1);
        bus.lzs = 1'b0;

        goto(260); load_val(16'h1111, 4'h0);
        goto(270); load_val(16'h2222, 4'h0);
        chk_digit("b2b_d0", 288, 0, 7'h24, 1'b1);
        chk_digit("b2b_d3", 288, 3, 7'h24, 1'b1);

        goto(300); load_val(16'h4444, 4'h0);
        goto(319); load_val(16'h5555, 4'h0);
        chk_digit("cmt_f1_d0", 320, 0, 7'h19, 1'b1);
        chk_digit("cmt_f1_d2", 320, 2, 7'h19, 1'b1);
        chk_digit("cmt_f2_d0", 352, 0, 7'h12, 1'b1);

        goto(356); load_val(16'h9999, 4'h0);
        goto(402); load_val(16'h7777, 4'h0);
        chk_digit("pre_rst_d2", 384, 2, 7'h10, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_an", bus.an, 4'hF);
        check("arst_seg", bus.seg, 7'h7F);
        check("arst_dp", bus.dp, 1'b1);
        check("arst_fd", bus.frame_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        chk_digit("post_d0", 0, 0, 7'h40, 1'b1);
        chk_digit("post_d3", 0, 3, 7'h40, 1'b1);
        chk_digit("lost_d0", 32, 0, 7'h40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Parametrised, time-multiplexed multi-digit 7-segment display driver. It replaces the single-digit combinational decoder: one shared segment bus drives NUM_DIGITS digits, with a digit-scan counter, double-buffered value loading, hex/BCD glyph modes, leading-zero suppression and anti-ghosting blanking. It sits between datapath result registers and the board display pins.

## Interface
- NUM_DIGITS, 4: digits driven; 1..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; ≥ 4.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1: 1 = segments and dp driven low-true; anodes are always active-low.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is least significant (rightmost).
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- load  in  1  sample value/dp_in into the staging register this cycle.
- hex_mode  in  1  1: codes 10–15 show A,b,C,d,E,F; 0: BCD, codes 10–15 show blank.
- lzs  in  1  leading-zero suppression enable.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point segment.
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all-high.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Prescaler pcnt counts 0..REFRESH_DIV-1, then wraps; tick = (pcnt == REFRESH_DIV-1).
- Digit index idx advances on tick; wraps NUM_DIGITS-1 → 0.
- frame_done = tick && idx == NUM_DIGITS-1 (registered, so it appears one cycle after that condition).
- Double buffering:
  - load=1 copies value/dp_in into staging and sets pending. A later load before commit overwrites staging; last one wins.
  - On the frame_done condition cycle, if pending, staging is copied to the display register and pending clears.
  - A load in the same cycle as commit goes to staging and leaves pending=1, so it is committed at the next frame.
  - Display never changes mid-frame.
- Glyphs, active-high before polarity: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Blank = 00.
- Leading-zero suppression: with lzs=1, digit i>0 is blanked if the display nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed. dp is still shown on a suppressed digit.
- Blanking: while pcnt < BLANK_CYCLES, an is all-high and seg/dp are off. Otherwise an[idx]=0, the other anodes are 1, and seg/dp show digit idx.
- SEG_ACTIVE_LOW=1 inverts seg and dp at the output register.

## Timing
- seg, dp, an and frame_done are registered with 1-cycle latency from pcnt/idx/display state. No combinational path exists from inputs to outputs.
- Reset values:
  - pcnt=0, idx=0, staging=0, display=0, pending=0.
  - an all-high, seg/dp off (all 1 when SEG_ACTIVE_LOW), frame_done=0.
- After reset release, an[0] first goes low at the edge after pcnt reaches BLANK_CYCLES, i.e. cycle BLANK_CYCLES+1.
- Each digit is lit for REFRESH_DIV-BLANK_CYCLES cycles per slot. Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Value latency: display updates at most one frame plus one cycle after load.
- Reset asserted mid-frame: all state returns to reset values immediately and asynchronously; pending loads are lost.
- hex_mode and lzs are sampled live (not double-buffered).

## Structure
- A shared package holds the 16-entry glyph constants, the blank constant, and a segment index map (SEG_A=0 … SEG_G=6).
- One sub-module, hex7_decode: combinational {nibble, hex_mode} → 7-bit active-high glyph. Instantiated once on the muxed nibble.
- The top level holds the prescaler, idx, staging/display registers, LZS logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1.
- Reset: hold rst_n=0 for 5 cycles → an=4'hF, seg=7'h7F, dp=1, frame_done=0. After release, an=4'hE from cycle 3 through cycle 8, then 4'hF for 2 cycles, then 4'hD.
- Load/commit: load value=16'h1234 mid-frame → the current frame still shows 0000. Next frame shows digit0 seg=~7'h66 ("4") and digit3 seg=~7'h06 ("1"). frame_done pulses every 32 cycles.
- Glyph modes: value=16'hABCF with hex_mode=1 → A,b,C,F glyphs. With hex_mode=0 → all four digits blank (seg=7'h7F while their anode is low).
- Leading-zero suppression: value=16'h0050, lzs=1 → digits 3 and 2 blank, digit1 "5", digit0 "0". value=16'h0000 → only digit0 shows "0".
- Back-to-back loads: load 16'h1111 and then 16'h2222 in the same frame → the next frame shows 2222. A load coinciding with the commit cycle appears one frame later.
- Reset mid-frame: assert rst_n=0 during digit 2 with 16'h9999 displayed → outputs go to reset values without waiting for a clock edge. After release the display shows 0000.
